store_load_order_checker: RTL and testbench

STORE_LOAD_ORDER_CHECKER -- requirements
Module: store_load_order_checker

---
 rtl/store_load_order_checker.sv | 103 ++++++++++
 tb/tb_store_load_order_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_load_order_checker.sv
// Load/store memory-ordering checker: flags the oldest already-executed load
// whose address matches a store that resolves later, and holds it for the ROB.
package lsu_pkg;
  localparam int LDQ_SIZE  = 8;
  localparam int STQ_SIZE  = 8;
  localparam int ROB_TAG_W = 6;

  typedef struct packed {
    logic                 valid;
    logic                 address_valid;
    logic [31:0]          address;
    logic [STQ_SIZE-1:0]  store_mask;
    logic                 succeeded;
    logic [ROB_TAG_W-1:0] rob_tag;
  } load_queue_entry;
endpackage

module store_load_order_checker #(
  parameter int LDQ_SIZE = lsu_pkg::LDQ_SIZE,
  parameter int STQ_SIZE = lsu_pkg::STQ_SIZE,
  parameter int CNT_W    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  lsu_pkg::load_queue_entry         load_queue_entries [LDQ_SIZE],
  input  logic [$clog2(LDQ_SIZE)-1:0]      ldq_head,
  input  logic                             stq_addr_resolve,
  input  logic [$clog2(STQ_SIZE)-1:0]      stq_resolve_index,
  input  logic [31:0]                      stq_resolve_address,
  input  logic                             flush_ack,
  output logic                             order_failure,
  output logic [$clog2(LDQ_SIZE)-1:0]      failing_ldq_index,
  output logic [lsu_pkg::ROB_TAG_W-1:0]    failing_rob_tag,
  output logic [CNT_W-1:0]                 failure_count
);

  localparam int IDX_W = $clog2(LDQ_SIZE);

  logic [LDQ_SIZE-1:0]           match;
  logic                          cand;
  logic [IDX_W-1:0]              cand_idx;
  logic [IDX_W-1:0]              cand_age;
  logic [lsu_pkg::ROB_TAG_W-1:0] cand_tag;
  logic [IDX_W-1:0]              pend_age;
  logic [IDX_W-1:0]              age_i;
  logic                          take;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < LDQ_SIZE; i++) begin
      match[i] = stq_addr_resolve
               & load_queue_entries[i].valid
               & load_queue_entries[i].address_valid
               & load_queue_entries[i].succeeded
               & load_queue_entries[i].store_mask[stq_resolve_index]
               & (load_queue_entries[i].address == stq_resolve_address);
    end
  end

  // Age is the head-relative distance; IDX_W-bit subtraction wraps modulo LDQ_SIZE.
  always_comb begin
    cand     = 1'b0;
    cand_idx = '0;
    cand_age = '0;
    cand_tag = '0;
    age_i    = '0;
    for (int unsigned i = 0; i < LDQ_SIZE; i++) begin
      age_i = IDX_W'(i) - ldq_head;
      if (match[i] && (!cand || (age_i < cand_age))) begin
        cand     = 1'b1;
        cand_idx = IDX_W'(i);
        cand_age = age_i;
        cand_tag = load_queue_entries[i].rob_tag;
      end
    end
  end

  assign pend_age = failing_ldq_index - ldq_head;
  assign take     = cand && (!order_failure || flush_ack || (cand_age < pend_age));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      order_failure     <= 1'b0;
      failing_ldq_index <= '0;
      failing_rob_tag   <= '0;
      failure_count     <= '0;
    end else begin
      if (take) begin
        order_failure     <= 1'b1;
        failing_ldq_index <= cand_idx;
        failing_rob_tag   <= cand_tag;
      end else if (!cand && flush_ack) begin
        order_failure     <= 1'b0;
        failing_ldq_index <= '0;
        failing_rob_tag   <= '0;
      end
      if (cand && (failure_count != '1)) begin
        failure_count <= failure_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_store_load_order_checker.sv
// Bench for store_load_order_checker: vector table, directed corner sequences
// and randomized traffic against an age-by-modular-distance reference model.
module tb_store_load_order_checker;
  import lsu_pkg::*;

  localparam int N = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  load_queue_entry      ldq [N];
  logic [2:0]           head;
  logic                 res;
  logic [2:0]           st_i;
  logic [31:0]          st_a;
  logic                 flush;

  logic                 of, of2;
  logic [2:0]           fi, fi2;
  logic [ROB_TAG_W-1:0] ft, ft2;
  logic [15:0]          fc;
  logic [1:0]           fc2;

  store_load_order_checker #(.LDQ_SIZE(8), .STQ_SIZE(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .load_queue_entries(ldq), .ldq_head(head),
    .stq_addr_resolve(res), .stq_resolve_index(st_i), .stq_resolve_address(st_a),
    .flush_ack(flush), .order_failure(of), .failing_ldq_index(fi),
    .failing_rob_tag(ft), .failure_count(fc)
  );

  store_load_order_checker #(.LDQ_SIZE(8), .STQ_SIZE(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .load_queue_entries(ldq), .ldq_head(head),
    .stq_addr_resolve(res), .stq_resolve_index(st_i), .stq_resolve_address(st_a),
    .flush_ack(flush), .order_failure(of2), .failing_ldq_index(fi2),
    .failing_rob_tag(ft2), .failure_count(fc2)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  bit m_fail;
  int m_idx, m_tag, m_cnt, m_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int age(input int i);
    return (i - int'(head) + N) % N;
  endfunction

  task automatic model_step();
    int best = -1;
    int ba   = 0;
    for (int i = 0; i < N; i++) begin
      if (res && ldq[i].valid && ldq[i].address_valid && ldq[i].succeeded &&
          ldq[i].store_mask[st_i] && (ldq[i].address == st_a)) begin
        if (best < 0 || age(i) < ba) begin
          best = i;
          ba   = age(i);
        end
      end
    end
    if (best >= 0) begin
      if (!m_fail || flush || ba < age(m_idx)) begin
        m_fail = 1'b1;
        m_idx  = best;
        m_tag  = int'(ldq[best].rob_tag);
      end
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (flush) begin
      m_fail = 1'b0;
      m_idx  = 0;
      m_tag  = 0;
    end
  endtask

  task automatic check_all();
    chk("order_failure", of, m_fail);
    chk("failing_ldq_index", fi, m_idx);
    chk("failing_rob_tag", ft, m_tag);
    chk("failure_count", fc, m_cnt);
    chk("sat_failure_count", fc2, m_cnt2);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_ldq();
    for (int i = 0; i < N; i++) ldq[i] = '0;
  endtask

  task automatic set_ld(input int i, input logic [31:0] a, input int mi, input int tag);
    ldq[i] = '0;
    ldq[i].valid         = 1'b1;
    ldq[i].address_valid = 1'b1;
    ldq[i].succeeded     = 1'b1;
    ldq[i].address       = a;
    ldq[i].store_mask[mi] = 1'b1;
    ldq[i].rob_tag       = ROB_TAG_W'(tag);
  endtask

  // Asserts reset between edges and checks outputs clear with no clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("reset_order_failure", of, 0);
    chk("reset_failing_ldq_index", fi, 0);
    chk("reset_failing_rob_tag", ft, 0);
    chk("reset_failure_count", fc, 0);
    chk("reset_sat_failure_count", fc2, 0);
    m_fail = 1'b0; m_idx = 0; m_tag = 0; m_cnt = 0; m_cnt2 = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    res   = 1'b0;
    flush = 1'b0;
  endtask

  typedef struct {
    int          ld_i;
    bit          v, av, s;
    int          mask_i;
    logic [31:0] ld_a;
    int          st_idx;
    logic [31:0] st_addr;
    bit          exp;
  } vec_t;

  vec_t vt [8];
  int   exp_sat [4];

  initial begin
    vt[0] = '{3, 1, 1, 1, 2, 32'h100, 2, 32'h100, 1};
    vt[1] = '{3, 1, 1, 0, 2, 32'h100, 2, 32'h100, 0};
    vt[2] = '{3, 1, 1, 1, 1, 32'h100, 2, 32'h100, 0};
    vt[3] = '{3, 1, 1, 1, 2, 32'h104, 2, 32'h100, 0};
    vt[4] = '{3, 0, 1, 1, 2, 32'h100, 2, 32'h100, 0};
    vt[5] = '{3, 1, 0, 1, 2, 32'h100, 2, 32'h100, 0};
    vt[6] = '{0, 1, 1, 1, 5, 32'h40, 5, 32'h40, 1};
    vt[7] = '{7, 1, 1, 1, 7, 32'hFFFF_FFFC, 7, 32'hFFFF_FFFC, 1};
    exp_sat = '{1, 2, 3, 3};

    reset = 1'b0; res = 1'b0; flush = 1'b0; head = '0; st_i = '0; st_a = '0;
    m_fail = 1'b0; m_idx = 0; m_tag = 0; m_cnt = 0; m_cnt2 = 0;
    clear_ldq();
    do_reset();

    // Saturation on the 2-bit counter instance
    set_ld(3, 32'h100, 2, 9);
    res = 1'b1; st_i = 3'd2; st_a = 32'h100;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("sat_sequence", fc2, exp_sat[k]);
    end
    res = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Vector table: basic detection and filters
    for (int k = 0; k < 8; k++) begin
      clear_ldq();
      head = '0;
      set_ld(vt[k].ld_i, vt[k].ld_a, vt[k].mask_i, 10 + k);
      ldq[vt[k].ld_i].valid         = vt[k].v;
      ldq[vt[k].ld_i].address_valid = vt[k].av;
      ldq[vt[k].ld_i].succeeded     = vt[k].s;
      res = 1'b1; st_i = 3'(vt[k].st_idx); st_a = vt[k].st_addr;
      cycle();
      chk("vec_order_failure", of, vt[k].exp);
      if (vt[k].exp) chk("vec_index", fi, vt[k].ld_i);
      res = 1'b0; flush = 1'b1;
      cycle();
      flush = 1'b0;
    end

    // Wrap-around oldest selection with head=6
    clear_ldq();
    head = 3'd6;
    set_ld(1, 32'h200, 4, 21);
    set_ld(7, 32'h200, 4, 27);
    res = 1'b1; st_i = 3'd4; st_a = 32'h200;
    cycle();
    chk("wrap_first", fi, 7);
    clear_ldq();
    set_ld(0, 32'h200, 4, 20);
    cycle();
    chk("wrap_younger_holds", fi, 7);
    clear_ldq();
    set_ld(6, 32'h200, 4, 26);
    cycle();
    chk("wrap_older_replaces", fi, 6);
    chk("wrap_older_tag", ft, 26);
    res = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Flush collision: ack and new candidate in the same cycle
    clear_ldq();
    head = '0;
    set_ld(3, 32'h300, 1, 33);
    res = 1'b1; st_i = 3'd1; st_a = 32'h300;
    cycle();
    chk("collision_pending", fi, 3);
    clear_ldq();
    set_ld(5, 32'h300, 1, 35);
    flush = 1'b1;
    cycle();
    chk("collision_index", fi, 5);
    chk("collision_order_failure", of, 1);
    res = 1'b0;
    cycle();
    chk("ack_clear_order_failure", of, 0);
    chk("ack_clear_index", fi, 0);
    flush = 1'b0;

    // Hold without ack, then reset in the middle of a pending failure
    do_reset();
    set_ld(2, 32'h400, 3, 42);
    res = 1'b1; st_i = 3'd3; st_a = 32'h400;
    cycle();
    cycle();
    res = 1'b0;
    cycle();
    chk("pending_count_before_reset", fc, 2);
    do_reset();

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      head = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        ldq[i].valid         = ($urandom % 4) != 0;
        ldq[i].address_valid = ($urandom % 4) != 0;
        ldq[i].succeeded     = ($urandom % 4) != 0;
        ldq[i].address       = 32'h100 + 32'(4 * $urandom_range(0, 2));
        ldq[i].store_mask    = 8'($urandom);
        ldq[i].rob_tag       = ROB_TAG_W'($urandom);
      end
      res   = ($urandom % 2) != 0;
      st_i  = 3'($urandom);
      st_a  = 32'h100 + 32'(4 * $urandom_range(0, 2));
      flush = ($urandom % 4) == 0;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
